// File: rtl/axis2fifo_pkg.sv
// axis2fifo_pkg
//   Shared types and helpers for the AXIS-to-FIFO receive adapter.
//   state_t   : controller state encoding (2 bits)
//   ptr_width : pointer width for a buffer of a given depth
package axis2fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Depth is a power of two >= 2, so clog2 is exact and pointers wrap
   // naturally; the floor of 1 keeps a degenerate depth from producing a
   // zero-width vector.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/axis2fifo_buf.sv
// axis2fifo_buf
//   DEPTH x (DATA_WIDTH+1) circular buffer, first-word-fall-through.
//   Each entry carries {last, data}.
//   Ports:
//     ACC_CLK, ARESETN      clock, synchronous active-low reset
//     push, wr_data, wr_last write one entry (caller guarantees not full)
//     pop                    pop head entry; ignored when empty
//     empty, full            occupancy flags
//     head_data, head_last   head entry; when empty, the last popped entry
module axis2fifo_buf #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2
) (
   input  logic                  ACC_CLK,
   input  logic                  ARESETN,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   input  logic                  pop,
   output logic                  empty,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);
   import axis2fifo_pkg::*;

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH:0] mem [DEPTH];
   logic [DATA_WIDTH:0] hold_q;
   logic [DATA_WIDTH:0] head;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic                pop_en;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign pop_en = pop & ~empty;

   // While empty, present the entry most recently popped so the output
   // holds steady instead of exposing a stale slot.
   assign head      = empty ? hold_q : mem[rd_ptr];
   assign head_data = head[DATA_WIDTH-1:0];
   assign head_last = head[DATA_WIDTH];

   always_ff @(posedge ACC_CLK) begin
      if (!ARESETN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         hold_q <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {wr_last, wr_data};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            hold_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis2fifo.sv
// axis2fifo
//   AXI-Stream slave presenting received beats as an FWFT FIFO read port.
//   CTRL_START arms a transfer; completion is reported once the beat
//   tagged TLAST has been popped by the accelerator.
//   Ports:
//     ACC_CLK, ARESETN             clock, synchronous active-low reset
//     CTRL_START/READY/FINISHED    transfer arm / ready / done level
//     BEAT_COUNT                   beats accepted since last CTRL_START
//     AXIS_TVALID/TDATA/TLAST      upstream stream
//     AXIS_TREADY                  beat accept, from registered state only
//     FIFO_EMPTY                   buffer empty, polarity per EMPTY_ACTIVE
//     FIFO_DOUT, FIFO_READ         FWFT head data and pop strobe
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | after reset, waiting for CTRL_START
//   RECV    | accepting beats until TLAST, draining to the accelerator
//   DONE    | TLAST entry popped; waiting for the next CTRL_START
module axis2fifo #(
   parameter int DATA_WIDTH   = 64,
   parameter int DEPTH        = 2,
   parameter int EMPTY_ACTIVE = 0,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                  ACC_CLK,
   input  logic                  ARESETN,
   input  logic                  CTRL_START,
   output logic                  CTRL_READY,
   output logic                  CTRL_FINISHED,
   output logic [CNT_WIDTH-1:0]  BEAT_COUNT,
   input  logic                  AXIS_TVALID,
   input  logic [DATA_WIDTH-1:0] AXIS_TDATA,
   input  logic                  AXIS_TLAST,
   output logic                  AXIS_TREADY,
   output logic                  FIFO_EMPTY,
   output logic [DATA_WIDTH-1:0] FIFO_DOUT,
   input  logic                  FIFO_READ
);
   import axis2fifo_pkg::*;

   state_t               state;
   logic                 last_seen;
   logic [CNT_WIDTH-1:0] beat_count;
   logic                 buf_empty;
   logic                 buf_full;
   logic                 head_last;
   logic                 push;
   logic                 pop;

   // Once TLAST is accepted the stream is held off until re-armed, so a
   // following packet never mixes into the current transfer.
   assign AXIS_TREADY   = (state == ST_RECV) & ~last_seen & ~buf_full;
   assign push          = AXIS_TVALID & AXIS_TREADY;
   assign pop           = FIFO_READ & ~buf_empty;

   assign CTRL_READY    = (state == ST_IDLE) | (state == ST_DONE);
   assign CTRL_FINISHED = (state == ST_DONE);
   assign BEAT_COUNT    = beat_count;
   assign FIFO_EMPTY    = (EMPTY_ACTIVE != 0) ? buf_empty : ~buf_empty;

   always_ff @(posedge ACC_CLK) begin
      if (!ARESETN) begin
         state      <= ST_IDLE;
         last_seen  <= 1'b0;
         beat_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (CTRL_START) begin
                  state      <= ST_RECV;
                  last_seen  <= 1'b0;
                  beat_count <= '0;
               end
            end
            ST_RECV: begin
               if (push) begin
                  beat_count <= beat_count + CNT_WIDTH'(1);
                  if (AXIS_TLAST) begin
                     last_seen <= 1'b1;
                  end
               end
               if (pop && head_last) begin
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   axis2fifo_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_buf (
      .ACC_CLK   (ACC_CLK),
      .ARESETN   (ARESETN),
      .push      (push),
      .wr_data   (AXIS_TDATA),
      .wr_last   (AXIS_TLAST),
      .pop       (pop),
      .empty     (buf_empty),
      .full      (buf_full),
      .head_data (FIFO_DOUT),
      .head_last (head_last)
   );

endmodule

// File: tb/tb_axis2fifo.sv
module tb_axis2fifo;

   logic        ACC_CLK = 1'b0;
   logic        ARESETN;
   logic        CTRL_START;
   logic        CTRL_READY;
   logic        CTRL_FINISHED;
   logic [31:0] BEAT_COUNT;
   logic        AXIS_TVALID;
   logic [63:0] AXIS_TDATA;
   logic        AXIS_TLAST;
   logic        AXIS_TREADY;
   logic        FIFO_EMPTY;
   logic [63:0] FIFO_DOUT;
   logic        FIFO_READ;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb_q[$];

   always #5 ACC_CLK = ~ACC_CLK;

   axis2fifo #(
      .DATA_WIDTH   (64),
      .DEPTH        (2),
      .EMPTY_ACTIVE (0),
      .CNT_WIDTH    (32)
   ) dut (
      .ACC_CLK       (ACC_CLK),
      .ARESETN       (ARESETN),
      .CTRL_START    (CTRL_START),
      .CTRL_READY    (CTRL_READY),
      .CTRL_FINISHED (CTRL_FINISHED),
      .BEAT_COUNT    (BEAT_COUNT),
      .AXIS_TVALID   (AXIS_TVALID),
      .AXIS_TDATA    (AXIS_TDATA),
      .AXIS_TLAST    (AXIS_TLAST),
      .AXIS_TREADY   (AXIS_TREADY),
      .FIFO_EMPTY    (FIFO_EMPTY),
      .FIFO_DOUT     (FIFO_DOUT),
      .FIFO_READ     (FIFO_READ)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge ACC_CLK);
      #1;
   endtask

   // Scoreboard: accepted beats are queued, every effective pop is compared
   // against the queue head. FIFO_EMPTY is active low, so 1 means data.
   always @(negedge ACC_CLK) begin
      if (ARESETN !== 1'b1) begin
         sb_q.delete();
      end else begin
         if (FIFO_READ && FIFO_EMPTY) begin
            if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else chk("sb_data", FIFO_DOUT, sb_q.pop_front());
         end
         if (AXIS_TVALID && AXIS_TREADY) sb_q.push_back(AXIS_TDATA);
      end
   end

   initial begin
      ARESETN     = 1'b0;
      CTRL_START  = 1'b0;
      AXIS_TVALID = 1'b0;
      AXIS_TDATA  = '0;
      AXIS_TLAST  = 1'b0;
      FIFO_READ   = 1'b0;
      cyc();
      cyc();
      ARESETN = 1'b1;
      cyc();

      // reset values
      chk("rst_ready",    CTRL_READY,    1);
      chk("rst_finished", CTRL_FINISHED, 0);
      chk("rst_tready",   AXIS_TREADY,   0);
      chk("rst_empty",    FIFO_EMPTY,    0);
      chk("rst_count",    BEAT_COUNT,    0);
      chk("rst_dout",     FIFO_DOUT,     0);

      // 4-beat packet with FIFO_READ held high
      CTRL_START = 1'b1;
      cyc();
      CTRL_START = 1'b0;
      chk("t1_ready_low", CTRL_READY, 0);
      FIFO_READ = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         AXIS_TVALID = 1'b1;
         AXIS_TDATA  = 64'(i);
         AXIS_TLAST  = (i == 4);
         chk("t1_tready", AXIS_TREADY, 1);
         if (i > 1) chk("t1_dout", FIFO_DOUT, 64'(i - 1));
         cyc();
      end
      AXIS_TVALID = 1'b0;
      AXIS_TLAST  = 1'b0;
      chk("t1_dout4",       FIFO_DOUT,     4);
      chk("t1_tready_last", AXIS_TREADY,   0);
      chk("t1_fin_early",   CTRL_FINISHED, 0);
      chk("t1_count",       BEAT_COUNT,    4);
      cyc();
      FIFO_READ = 1'b0;
      chk("t1_finished", CTRL_FINISHED, 1);
      chk("t1_ready",    CTRL_READY,    1);
      chk("t1_empty",    FIFO_EMPTY,    0);

      // backpressure at DEPTH=2 with FIFO_READ low
      CTRL_START = 1'b1;
      cyc();
      CTRL_START  = 1'b0;
      chk("t2_count0", BEAT_COUNT, 0);
      AXIS_TVALID = 1'b1;
      AXIS_TDATA  = 64'hA;
      chk("t2_tready_a", AXIS_TREADY, 1);
      cyc();
      AXIS_TDATA = 64'hB;
      chk("t2_tready_b", AXIS_TREADY, 1);
      cyc();
      AXIS_TDATA = 64'hC;
      chk("t2_full_tready", AXIS_TREADY, 0);
      chk("t2_head_a",      FIFO_DOUT,   64'hA);
      chk("t2_count2",      BEAT_COUNT,  2);
      cyc();
      chk("t2_still_full", AXIS_TREADY, 0);
      FIFO_READ = 1'b1;
      cyc();
      FIFO_READ = 1'b0;
      chk("t2_tready_c", AXIS_TREADY, 1);
      chk("t2_head_b",   FIFO_DOUT,   64'hB);
      cyc();
      AXIS_TVALID = 1'b0;
      chk("t2_refull", AXIS_TREADY, 0);
      chk("t2_count3", BEAT_COUNT,  3);
      FIFO_READ = 1'b1;
      cyc();
      cyc();
      FIFO_READ = 1'b0;
      chk("t2_drained",  FIFO_EMPTY,    0);
      chk("t2_not_done", CTRL_FINISHED, 0);

      // FIFO_READ pulsed while empty, still in RECV
      FIFO_READ = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t5_empty", FIFO_EMPTY, 0);
      end
      FIFO_READ   = 1'b0;
      AXIS_TVALID = 1'b1;
      AXIS_TDATA  = 64'h55;
      AXIS_TLAST  = 1'b1;
      chk("t5_tready", AXIS_TREADY, 1);
      cyc();
      AXIS_TVALID = 1'b0;
      AXIS_TLAST  = 1'b0;
      chk("t5_nonempty", FIFO_EMPTY,  1);
      chk("t5_dout",     FIFO_DOUT,   64'h55);
      chk("t5_tready0",  AXIS_TREADY, 0);
      chk("t5_count",    BEAT_COUNT,  4);
      FIFO_READ = 1'b1;
      cyc();
      FIFO_READ = 1'b0;
      cyc();
      chk("t5_finished", CTRL_FINISHED, 1);

      // 16 beats streaming, no bubbles
      CTRL_START = 1'b1;
      cyc();
      CTRL_START = 1'b0;
      FIFO_READ  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         AXIS_TVALID = 1'b1;
         AXIS_TDATA  = 64'h100 + 64'(i);
         AXIS_TLAST  = (i == 15);
         chk("t3_tready", AXIS_TREADY, 1);
         cyc();
      end
      AXIS_TVALID = 1'b0;
      AXIS_TLAST  = 1'b0;
      cyc();
      FIFO_READ = 1'b0;
      chk("t3_finished", CTRL_FINISHED, 1);
      chk("t3_count",    BEAT_COUNT,    16);

      // TLAST on beat 2, beat 3 stalled until next CTRL_START
      CTRL_START = 1'b1;
      cyc();
      CTRL_START  = 1'b0;
      FIFO_READ   = 1'b1;
      AXIS_TVALID = 1'b1;
      AXIS_TDATA  = 64'h201;
      cyc();
      AXIS_TDATA = 64'h202;
      AXIS_TLAST = 1'b1;
      chk("t4_tready2", AXIS_TREADY, 1);
      cyc();
      AXIS_TDATA = 64'h203;
      AXIS_TLAST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4_stall", AXIS_TREADY, 0);
         cyc();
      end
      FIFO_READ = 1'b0;
      chk("t4_finished", CTRL_FINISHED, 1);
      chk("t4_stall_done", AXIS_TREADY, 0);
      CTRL_START = 1'b1;
      cyc();
      CTRL_START = 1'b0;
      AXIS_TLAST = 1'b1;
      chk("t4_rearm", AXIS_TREADY, 1);
      chk("t4_count0", BEAT_COUNT, 0);
      cyc();
      AXIS_TVALID = 1'b0;
      AXIS_TLAST  = 1'b0;
      chk("t4_dout3",  FIFO_DOUT,  64'h203);
      chk("t4_count1", BEAT_COUNT, 1);
      FIFO_READ = 1'b1;
      cyc();
      FIFO_READ = 1'b0;
      cyc();
      chk("t4_fin2", CTRL_FINISHED, 1);

      // reset with 2 beats buffered
      CTRL_START = 1'b1;
      cyc();
      CTRL_START  = 1'b0;
      AXIS_TVALID = 1'b1;
      AXIS_TDATA  = 64'h301;
      cyc();
      AXIS_TDATA = 64'h302;
      cyc();
      AXIS_TVALID = 1'b0;
      chk("t6_buffered", FIFO_EMPTY, 1);
      chk("t6_count2",   BEAT_COUNT, 2);
      ARESETN = 1'b0;
      cyc();
      ARESETN = 1'b1;
      chk("t6_empty",    FIFO_EMPTY,    0);
      chk("t6_count",    BEAT_COUNT,    0);
      chk("t6_tready",   AXIS_TREADY,   0);
      chk("t6_ready",    CTRL_READY,    1);
      chk("t6_finished", CTRL_FINISHED, 0);

      // post-reset transfer still works
      CTRL_START = 1'b1;
      cyc();
      CTRL_START  = 1'b0;
      AXIS_TVALID = 1'b1;
      AXIS_TDATA  = 64'h401;
      AXIS_TLAST  = 1'b1;
      cyc();
      AXIS_TVALID = 1'b0;
      AXIS_TLAST  = 1'b0;
      chk("t7_dout", FIFO_DOUT, 64'h401);
      FIFO_READ = 1'b1;
      cyc();
      FIFO_READ = 1'b0;
      cyc();
      chk("t7_finished", CTRL_FINISHED, 1);
      chk("sb_drain", 64'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis2fifo.md
Name: axis2fifo

Overview:
AXI-Stream slave that accepts a packet from an upstream AXIS master and presents it to the accelerator as a first-word-fall-through FIFO read interface. It is the receive-side counterpart of the transmit adapter in the adapter IP. A small internal buffer decouples TREADY from the accelerator's read strobe. A control handshake arms each transfer and reports completion once the TLAST beat has been read out.

Parameters:
DATA_WIDTH, 64, width of AXIS_TDATA and FIFO_DOUT.
DEPTH, 2, internal buffer entries; power of two, at least 2.
EMPTY_ACTIVE, 0, polarity of FIFO_EMPTY: 0 = active low, 1 = active high.
CNT_WIDTH, 32, width of BEAT_COUNT.

Ports:
ACC_CLK  in  1  clock, all logic rising-edge.
ARESETN  in  1  reset, synchronous, active-low.
CTRL_START  in  1  arms a transfer; sampled in IDLE or DONE.
CTRL_READY  out  1  high in IDLE or DONE, i.e. CTRL_START will be accepted.
CTRL_FINISHED  out  1  level; high in DONE.
BEAT_COUNT  out  CNT_WIDTH  beats accepted on AXIS since the last accepted CTRL_START.
AXIS_TVALID  in  1  upstream beat valid.
AXIS_TDATA  in  DATA_WIDTH  upstream data.
AXIS_TLAST  in  1  upstream last beat of packet.
AXIS_TREADY  out  1  adapter accepts a beat.
FIFO_EMPTY  out  1  buffer empty, polarity set by EMPTY_ACTIVE.
FIFO_DOUT  out  DATA_WIDTH  head-of-buffer data (FWFT).
FIFO_READ  in  1  pop head entry.

Behaviour:
- Reset values: state IDLE, buffer count 0, last_seen 0, BEAT_COUNT 0, AXIS_TREADY 0, FIFO_DOUT 0, FIFO_EMPTY asserted, CTRL_READY 1, CTRL_FINISHED 0.
- States:
  - IDLE --CTRL_START--> RECV.
  - RECV --pop of the entry tagged last--> DONE.
  - DONE --CTRL_START--> RECV.
  - DONE holds indefinitely otherwise.
- On an accepted CTRL_START: BEAT_COUNT <= 0, last_seen <= 0. The buffer is already empty at this point by construction.
- AXIS_TREADY = (state==RECV) & ~last_seen & (count < DEPTH). It is combinational from registered state only, with no path from AXIS_TVALID.
- Push (AXIS_TVALID & AXIS_TREADY):
  - write {TLAST, TDATA} at the write pointer; count+1.
  - BEAT_COUNT+1, wrapping modulo 2^CNT_WIDTH.
  - if TLAST, last_seen <= 1 on that edge, so TREADY drops the next cycle.
- Pop (FIFO_READ & buffer not empty):
  - advance the read pointer; count-1.
  - FIFO_DOUT shows the next entry the following cycle, zero-bubble.
- FIFO_READ while empty is ignored: no pointer or count change, no error.
- Simultaneous push and pop: count unchanged and both pointers advance. When count==DEPTH, TREADY is already 0, so a same-cycle push at full cannot occur.
- FIFO_DOUT:
  - equals the head entry when non-empty.
  - holds its last value when empty; the value is don't-care but must not be X after reset.
- FIFO_EMPTY: count==0, inverted when EMPTY_ACTIVE=0.
- Latency: a beat accepted on edge N is visible on FIFO_DOUT, with FIFO_EMPTY deasserted, after edge N; read-able from cycle N+1.
- Completion:
  - the pop of the last-tagged entry moves RECV to DONE on the same edge.
  - CTRL_FINISHED=1 from the next cycle.
  - beats arriving after TLAST stay stalled (TREADY=0) until the next CTRL_START.
- Packet without TLAST: RECV persists, with BEAT_COUNT still counting; only ARESETN recovers.
- Reset mid-transfer: buffered data is discarded, all state returns to reset values, and the upstream master sees TREADY=0 from the cycle after reset is sampled.
- CTRL_START while in RECV is ignored.

Decomposition:
- Package axis2fifo_pkg:
  - state enum IDLE/RECV/DONE, 2-bit encoding.
  - helper constant for pointer width, clog2(DEPTH).
- One sub-module axis2fifo_buf:
  - DEPTH x (DATA_WIDTH+1) circular buffer with push/pop, count, head data and head-last outputs.
  - the top level holds the FSM, TREADY logic, counter and polarity generation.

Test Plan:
- Reset then CTRL_START, stream 4 beats 0x1..0x4 (TLAST on 0x4), FIFO_READ held high -> FIFO_DOUT shows 1,2,3,4 on consecutive cycles; BEAT_COUNT=4; CTRL_FINISHED=1 one cycle after the 0x4 pop.
- FIFO_READ held low, TVALID held high with data 0xA,0xB,0xC -> TREADY drops after 2 accepts (DEPTH=2), FIFO_DOUT=0xA; one FIFO_READ pulse -> TREADY returns for exactly one beat, 0xC, accepted.
- TVALID continuous with FIFO_READ continuous, 16 beats -> one beat per cycle, no bubbles, count never exceeds 1.
- TLAST on beat 2, upstream keeps TVALID=1 with beat 3 -> TREADY=0 from the cycle after the TLAST accept until CTRL_START; beat 3 delivered in the next transfer.
- FIFO_READ pulsed while empty, EMPTY_ACTIVE=0 -> FIFO_EMPTY=0 throughout, no pointer change, next pushed beat read correctly.
- ARESETN low for 1 cycle with 2 beats buffered mid-RECV -> FIFO_EMPTY asserted, BEAT_COUNT=0, state IDLE, TREADY=0, CTRL_READY=1.
